wb_channel_slice: RTL

//  Registered Wishbone B3 decoupling slice between one upstream master (s_*) and one downstream slave (m_*).

---
 rtl/wb_channel_pkg.sv | 31 +++
 rtl/wb_channel_slice_timer.sv | 34 +++
 rtl/wb_channel_slice.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wb_channel_pkg.sv
// Shared types and constants for the Wishbone channel slice.
package wb_channel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RESP_ACK = 2'd0,
        RESP_ERR = 2'd1,
        RESP_RTY = 2'd2
    } resp_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Several terminations at once resolve as err > rty > ack.
    function automatic resp_t resolve_resp(input logic err, input logic rty);
        if (err)
            return RESP_ERR;
        else if (rty)
            return RESP_RTY;
        else
            return RESP_ACK;
    endfunction

endpackage

// File: rtl/wb_channel_slice_timer.sv
// Watchdog counter for the channel slice: expired_o flags the LIMIT-th enabled cycle since clear.
module wb_channel_slice_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired_o = enable_i && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_channel_slice.sv
// Registered Wishbone B3 slice: one beat at a time, each upstream beat issued downstream as a classic cycle.
// Define WB_CHANNEL_SLICE_TIMEOUT_EN to add a watchdog that errors out hung downstream cycles.
module wb_channel_slice
    import wb_channel_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_cyc_i,
    input  logic                    s_stb_i,
    input  logic                    s_we_i,
    input  logic [ADDR_WIDTH-1:0]   s_adr_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic [DATA_WIDTH/8-1:0] s_sel_i,
    input  logic [2:0]              s_cti_i,
    input  logic [1:0]              s_bte_i,
    output logic                    s_ack_o,
    output logic                    s_err_o,
    output logic                    s_rty_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [ADDR_WIDTH-1:0]   m_adr_o,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic [DATA_WIDTH/8-1:0] m_sel_o,
    output logic [2:0]              m_cti_o,
    output logic [1:0]              m_bte_o,
    input  logic                    m_ack_i,
    input  logic                    m_err_i,
    input  logic                    m_rty_i,
    input  logic [DATA_WIDTH-1:0]   m_dat_i
);

    state_t                  state_q, state_d;
    logic                    m_cyc_q, m_cyc_d;
    logic                    m_we_q, m_we_d;
    logic [ADDR_WIDTH-1:0]   m_adr_q, m_adr_d;
    logic [DATA_WIDTH-1:0]   m_dat_q, m_dat_d;
    logic [DATA_WIDTH/8-1:0] m_sel_q, m_sel_d;
    logic                    s_ack_q, s_ack_d;
    logic                    s_err_q, s_err_d;
    logic                    s_rty_q, s_rty_d;
    logic [DATA_WIDTH-1:0]   s_dat_q, s_dat_d;
    logic                    term;
    logic                    timeout_hit;
    resp_t                   resp;

    // Burst qualifiers are accepted but every beat goes out as a classic cycle.
    logic unused_burst;
    assign unused_burst = ^{s_cti_i, s_bte_i};

`ifdef WB_CHANNEL_SLICE_TIMEOUT_EN
    wb_channel_slice_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q == WAIT),
        .expired_o(timeout_hit)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign term = m_ack_i | m_err_i | m_rty_i;

    always_comb begin
        state_d = state_q;
        m_cyc_d = m_cyc_q;
        m_we_d  = m_we_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
        m_sel_d = m_sel_q;
        s_ack_d = 1'b0;
        s_err_d = 1'b0;
        s_rty_d = 1'b0;
        s_dat_d = s_dat_q;
        resp    = resolve_resp(m_err_i, m_rty_i);
        case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    m_we_d  = s_we_i;
                    m_adr_d = s_adr_i;
                    m_dat_d = s_dat_i;
                    m_sel_d = s_sel_i;
                    m_cyc_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A real termination in the expiry cycle takes precedence over the watchdog.
                if (term || timeout_hit) begin
                    if (!term)
                        resp = RESP_ERR;
                    if (term && !m_we_q)
                        s_dat_d = m_dat_i;
                    s_ack_d = (resp == RESP_ACK);
                    s_err_d = (resp == RESP_ERR);
                    s_rty_d = (resp == RESP_RTY);
                    m_cyc_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_cyc_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            m_sel_q <= '0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            s_rty_q <= 1'b0;
            s_dat_q <= '0;
        end else begin
            state_q <= state_d;
            m_cyc_q <= m_cyc_d;
            m_we_q  <= m_we_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
            m_sel_q <= m_sel_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_rty_q <= s_rty_d;
            s_dat_q <= s_dat_d;
        end
    end

    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_cyc_q;
    assign m_we_o  = m_we_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign m_sel_o = m_sel_q;
    assign m_cti_o = CTI_CLASSIC;
    assign m_bte_o = BTE_LINEAR;
    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_rty_o = s_rty_q;
    assign s_dat_o = s_dat_q;

endmodule
